// File: rtl/centering_pkg.sv
// Shared definitions for the frame-mean centering engine: FSM state encoding
// and signed saturation limits derived from the sample width.
package centering_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ACCUM = 3'd1;
  localparam state_t ST_MEAN  = 3'd2;
  localparam state_t ST_SUB   = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/centering_lane.sv
// One channel of the centering engine: frame accumulator, rounded mean
// register and saturating mean subtraction with a registered output.
module centering_lane
  import centering_pkg::*;
#(
  parameter int W       = 26,
  parameter int LOG2_NS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_acc_en,
  input  logic                i_mean_en,
  input  logic                i_sub_en,
  input  logic signed [W-1:0] i_x,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_mean
);

  localparam int AW = W + LOG2_NS;
  localparam logic signed [AW-1:0] HALF    = AW'(longint'(1) <<< (LOG2_NS - 1));
  localparam logic signed [W:0]    SAT_MAX = (W + 1)'(sat_max(W));
  localparam logic signed [W:0]    SAT_MIN = (W + 1)'(sat_min(W));

  logic signed [AW-1:0] r_acc;
  logic signed [W-1:0]  r_mean;
  logic signed [W-1:0]  r_x;
  logic signed [AW-1:0] w_rnd;
  logic signed [AW-1:0] w_shift;
  logic signed [W:0]    w_diff;
  logic signed [W-1:0]  w_sat;

  // Round half up, then arithmetic shift so negative sums floor correctly.
  assign w_rnd   = r_acc + HALF;
  assign w_shift = w_rnd >>> LOG2_NS;
  assign w_diff  = {i_x[W-1], i_x} - {r_mean[W-1], r_mean};

  // NOTE: default assignment first so every path drives w_sat and no latch is inferred.
  always_comb begin
    w_sat = w_diff[W-1:0];
    if (w_diff > SAT_MAX)      w_sat = SAT_MAX[W-1:0];
    else if (w_diff < SAT_MIN) w_sat = SAT_MIN[W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_mean <= '0;
      r_x    <= '0;
    end else begin
      if (i_clear)        r_acc  <= '0;
      else if (i_acc_en)  r_acc  <= r_acc + AW'(i_x);
      if (i_mean_en)      r_mean <= w_shift[W-1:0];
      if (i_sub_en)       r_x    <= w_sat;
    end
  end

  assign o_x    = r_x;
  assign o_mean = r_mean;

endmodule

// File: rtl/centering_engine.sv
// Frame-based DC removal: accumulates NS samples per channel, computes the
// rounded mean, then subtracts it from a second pass of NS samples.
module centering_engine
  import centering_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int W       = 26,
  parameter int LOG2_NS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] x_in,
  output logic             out_valid,
  output logic [NCH*W-1:0] x_out,
  output logic [NCH*W-1:0] mean_out,
  output logic             mean_valid,
  output logic             busy,
  output logic             done
);

  state_t              r_state;
  logic [LOG2_NS-1:0]  r_cnt;
  logic                r_out_valid;
  logic                r_mean_valid;

  logic w_start;
  logic w_acc_en;
  logic w_mean_en;
  logic w_sub_en;
  logic w_last;

  assign w_start   = (r_state == ST_IDLE) && go;
  assign w_acc_en  = (r_state == ST_ACCUM) && in_valid;
  assign w_mean_en = (r_state == ST_MEAN);
  assign w_sub_en  = (r_state == ST_SUB) && in_valid;
  assign w_last    = &r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_mean_valid <= 1'b0;
    end else begin
      r_out_valid <= w_sub_en;
      if (w_start)        r_cnt <= '0;
      else if (w_acc_en || w_sub_en) r_cnt <= r_cnt + 1'b1;

      if (w_start)        r_mean_valid <= 1'b0;
      else if (w_mean_en) r_mean_valid <= 1'b1;

      case (r_state)
        ST_IDLE:  if (go) r_state <= ST_ACCUM;
        ST_ACCUM: if (w_acc_en && w_last) r_state <= ST_MEAN;
        ST_MEAN:  r_state <= ST_SUB;
        ST_SUB:   if (w_sub_en && w_last) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    centering_lane #(
      .W       (W),
      .LOG2_NS (LOG2_NS)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_start),
      .i_acc_en  (w_acc_en),
      .i_mean_en (w_mean_en),
      .i_sub_en  (w_sub_en),
      .i_x       (x_in[k*W +: W]),
      .o_x       (x_out[k*W +: W]),
      .o_mean    (mean_out[k*W +: W])
    );
  end

  assign out_valid  = r_out_valid;
  assign mean_valid = r_mean_valid;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_centering_engine.sv
// Directed self-checking bench for centering_engine with 4-sample frames.
module tb_centering_engine;

  localparam int NCH = 4;
  localparam int W   = 26;
  localparam int L   = 2;
  localparam int VW  = NCH * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic          in_valid;
  logic [VW-1:0] x_in;
  logic          out_valid;
  logic [VW-1:0] x_out;
  logic [VW-1:0] mean_out;
  logic          mean_valid;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  centering_engine #(.NCH(NCH), .W(W), .LOG2_NS(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .in_valid   (in_valid),
    .x_in       (x_in),
    .out_valid  (out_valid),
    .x_out      (x_out),
    .mean_out   (mean_out),
    .mean_valid (mean_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [VW-1:0] v;
    v[0*W +: W] = W'(c0);
    v[1*W +: W] = W'(c1);
    v[2*W +: W] = W'(c2);
    v[3*W +: W] = W'(c3);
    return v;
  endfunction

  function automatic logic signed [63:0] lane(input logic [VW-1:0] v, input int k);
    logic signed [W-1:0] s;
    s = v[k*W +: W];
    return 64'(s);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    for (int k = 0; k < NCH; k++) chk($sformatf("%s[%0d]", tag, k), lane(obs, k), lane(exp, k));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame: accumulate a[], then replay s[] and expect e[].
  task automatic run_frame(input string tag,
                           input logic [VW-1:0] a0, input logic [VW-1:0] a1,
                           input logic [VW-1:0] a2, input logic [VW-1:0] a3,
                           input logic [VW-1:0] s0, input logic [VW-1:0] s1,
                           input logic [VW-1:0] s2, input logic [VW-1:0] s3,
                           input logic [VW-1:0] m,
                           input logic [VW-1:0] e0, input logic [VW-1:0] e1,
                           input logic [VW-1:0] e2, input logic [VW-1:0] e3,
                           input int gap, input bit go_noise);
    logic [VW-1:0] a[4];
    logic [VW-1:0] s[4];
    logic [VW-1:0] e[4];
    a = '{a0, a1, a2, a3};
    s = '{s0, s1, s2, s3};
    e = '{e0, e1, e2, e3};
    go = 1'b1;
    tick();
    go = 1'b0;
    chk({tag, ".busy_start"}, 64'(busy), 64'(1));
    chk({tag, ".mv_cleared"}, 64'(mean_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      x_in = a[i];
      in_valid = 1'b1;
      if (go_noise && i == 1) go = 1'b1;
      tick();
      in_valid = 1'b0;
      go = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
    tick();
    chk({tag, ".mean_valid"}, 64'(mean_valid), 64'(1));
    chk_vec({tag, ".mean"}, mean_out, m);
    chk({tag, ".ov_before_sub"}, 64'(out_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      x_in = s[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("%s.ov%0d", tag, i), 64'(out_valid), 64'(1));
      chk_vec($sformatf("%s.x%0d", tag, i), x_out, e[i]);
      if (i < 3) begin
        chk($sformatf("%s.nodone%0d", tag, i), 64'(done), 64'(0));
        for (int g = 0; g < gap; g++) begin
          tick();
          chk($sformatf("%s.gap_ov%0d", tag, i), 64'(out_valid), 64'(0));
          chk($sformatf("%s.gap_hold%0d", tag, i), lane(x_out, 0), lane(e[i], 0));
        end
      end
    end
    chk({tag, ".done"}, 64'(done), 64'(1));
    chk({tag, ".busy_done"}, 64'(busy), 64'(1));
    if (go_noise) go = 1'b1;
    tick();
    go = 1'b0;
    chk({tag, ".done_pulse"}, 64'(done), 64'(0));
    chk({tag, ".idle"}, 64'(busy), 64'(0));
    chk({tag, ".ov_idle"}, 64'(out_valid), 64'(0));
    chk({tag, ".mv_hold"}, 64'(mean_valid), 64'(1));
    chk_vec({tag, ".mean_hold"}, mean_out, m);
    tick();
    chk({tag, ".no_restart"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    go       = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.mean_valid", 64'(mean_valid), 64'(0));
    chk_vec("rst.x_out", x_out, '0);
    chk_vec("rst.mean_out", mean_out, '0);

    // Constant frame.
    run_frame("const",
              pk(100, 100, 100, 100), pk(100, 100, 100, 100),
              pk(100, 100, 100, 100), pk(100, 100, 100, 100),
              pk(100, 100, 100, 100), pk(100, 100, 100, 100),
              pk(100, 100, 100, 100), pk(100, 100, 100, 100),
              pk(100, 100, 100, 100),
              pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0),
              0, 1'b0);

    // ch0 ramp, ch1 negative rounding, ch2 saturation, ch3 constant.
    run_frame("mix",
              pk(1, -1, -33554432, 7), pk(2, -2, -33554432, 7),
              pk(3, -2, -33554432, 7), pk(4, -2, 33554431, 7),
              pk(1, -1, 33554431, 7), pk(2, -2, -33554432, 7),
              pk(3, -2, 0, 7), pk(4, -2, 0, 7),
              pk(3, -2, -16777216, 7),
              pk(-2, 1, 33554431, 0), pk(-1, 0, -16777216, 0),
              pk(0, 0, 16777216, 0), pk(1, 0, 16777216, 0),
              0, 1'b0);

    // Reset in the middle of accumulation abandons the frame.
    go = 1'b1;
    tick();
    go = 1'b0;
    x_in = pk(50, 50, 50, 50);
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.mean_valid", 64'(mean_valid), 64'(0));
    chk("midrst.done", 64'(done), 64'(0));
    chk_vec("midrst.mean_out", mean_out, '0);
    repeat (3) begin
      tick();
      chk("midrst.no_done", 64'(done), 64'(0));
    end

    run_frame("post_rst",
              pk(1, 1, 1, 1), pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(4, 4, 4, 4),
              pk(1, 1, 1, 1), pk(2, 2, 2, 2), pk(3, 3, 3, 3), pk(4, 4, 4, 4),
              pk(3, 3, 3, 3),
              pk(-2, -2, -2, -2), pk(-1, -1, -1, -1), pk(0, 0, 0, 0), pk(1, 1, 1, 1),
              0, 1'b0);

    // Gapped in_valid with stray go pulses in ACCUM and DONE.
    run_frame("gapped",
              pk(1, -1, 10, -10), pk(2, -2, 20, -20),
              pk(3, -2, 30, -30), pk(4, -2, 40, -40),
              pk(1, -1, 10, -10), pk(2, -2, 20, -20),
              pk(3, -2, 30, -30), pk(4, -2, 40, -40),
              pk(3, -2, 25, -25),
              pk(-2, 1, -15, 15), pk(-1, 0, -5, 5), pk(0, 0, 5, -5), pk(1, 0, 15, -15),
              2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
